// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / serial checker pair:
// receiver state encoding and the odd-parity helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int ODD_PAR_MAX_W = 16;

  // Narrower words are zero-extended by the caller; zeros do not change parity.
  function automatic logic odd_par(input logic [ODD_PAR_MAX_W-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/parity_serial_chk.sv
// Serial frame receiver: start bit, W data bits (LSB first), odd parity bit,
// stop bit. Reports the word with parity/framing status and a saturating error count.
module parity_serial_chk
  import parity_pkg::*;
#(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  output logic             par_err,
  output logic             frm_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int BC_W = $clog2(W + 1);

  state_e             state_q, state_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic               pbit_q, pbit_d;
  logic [W-1:0]       dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      pbit_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      pbit_q       <= pbit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    pbit_d       = pbit_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    err_cnt_d    = err_cnt_q;

    if (sin_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          // New bit enters at the MSB so the first bit ends up in bit 0.
          shreg_d   = (shreg_q >> 1) | (W'(sin) << (W - 1));
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_W'(W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          pbit_d  = sin;
          state_d = STOP;
        end
        STOP: begin
          dout_d       = shreg_q;
          par_err_d    = odd_par(ODD_PAR_MAX_W'(shreg_q)) ^ pbit_q;
          frm_err_d    = ~sin;
          dout_valid_d = 1'b1;
          if ((par_err_d || frm_err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign par_err    = par_err_q;
  assign frm_err    = frm_err_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_serial_chk.sv
// Self-checking bench for parity_serial_chk (W=3, CNT_W=8): directed table,
// gap/idle/reset corner cases, randomized frames and error-counter saturation.
module tb_parity_serial_chk;
  import parity_pkg::*;

  localparam int W     = 3;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sin = 1'b1;
  logic             sin_valid = 1'b0;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             par_err;
  logic             frm_err;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  parity_serial_chk #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .par_err    (par_err),
    .frm_err    (frm_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [W-1:0] last_dout = '0;

  typedef struct {
    logic [W-1:0] data;
    logic         p;
    logic         stop;
    logic [W-1:0] exp_dout;
    logic         exp_pe;
    logic         exp_fe;
    int           exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: a good frame has an odd number of ones over data + parity.
  function automatic logic model_pe(input logic [W-1:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) == 0);
  endfunction

  task automatic strobe(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin       = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      sin = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic p, input logic stop,
                            input int maxgap, input string tag);
    logic [W+2:0] bits;
    logic         bad;
    logic         pe;
    logic         fe;
    bits = {stop, p, data, 1'b0};
    bad  = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      idle_cycles($urandom_range(0, maxgap));
      if (i > 0) begin
        if (dout_valid !== 1'b0 || busy !== 1'b1 || dout !== last_dout) bad = 1'b1;
      end
      strobe(bits[i]);
    end
    pe = model_pe(data, p);
    fe = ~stop;
    if ((pe || fe) && exp_cnt < CNT_MAX) exp_cnt++;
    chk($sformatf("%s in_frame", tag), 32'(bad), 32'd0);
    chk($sformatf("%s dout_valid", tag), 32'(dout_valid), 32'd1);
    chk($sformatf("%s dout", tag), 32'(dout), 32'(data));
    chk($sformatf("%s par_err", tag), 32'(par_err), 32'(pe));
    chk($sformatf("%s frm_err", tag), 32'(frm_err), 32'(fe));
    chk($sformatf("%s err_cnt", tag), 32'(err_cnt), 32'(exp_cnt));
    chk($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    last_dout = data;
  endtask

  vec_t vecs[4];

  initial begin
    logic bad;
    logic [W-1:0] d;
    logic p;
    logic s;

    vecs[0] = '{data: 3'b101, p: 1'b1, stop: 1'b1, exp_dout: 3'b101, exp_pe: 1'b0, exp_fe: 1'b0, exp_cnt: 0};
    vecs[1] = '{data: 3'b101, p: 1'b0, stop: 1'b1, exp_dout: 3'b101, exp_pe: 1'b1, exp_fe: 1'b0, exp_cnt: 1};
    vecs[2] = '{data: 3'b000, p: 1'b1, stop: 1'b0, exp_dout: 3'b000, exp_pe: 1'b0, exp_fe: 1'b1, exp_cnt: 2};
    vecs[3] = '{data: 3'b011, p: 1'b1, stop: 1'b1, exp_dout: 3'b011, exp_pe: 1'b0, exp_fe: 1'b0, exp_cnt: 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst dout", 32'(dout), 32'd0);
    chk("rst dout_valid", 32'(dout_valid), 32'd0);
    chk("rst par_err", 32'(par_err), 32'd0);
    chk("rst frm_err", 32'(frm_err), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].p, vecs[i].stop, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d tbl_pe", i), 32'(par_err), 32'(vecs[i].exp_pe));
      chk($sformatf("vec%0d tbl_fe", i), 32'(frm_err), 32'(vecs[i].exp_fe));
      chk($sformatf("vec%0d tbl_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_cnt));
    end

    // Idle strobes with line high, then a gappy frame.
    idle_cycles(3);
    bad = 1'b0;
    repeat (10) begin
      strobe(1'b1);
      if (busy !== 1'b0 || dout_valid !== 1'b0) bad = 1'b1;
    end
    chk("idle busy", 32'(bad), 32'd0);
    send_frame(3'b101, 1'b1, 1'b1, 5, "gappy");

    // Reset after second data bit discards the partial frame.
    idle_cycles(2);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort dout_valid", 32'(dout_valid), 32'd0);
    chk("abort err_cnt", 32'(err_cnt), 32'd0);
    chk("abort dout", 32'(dout), 32'd0);
    exp_cnt   = 0;
    last_dout = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      strobe(1'b1);
      if (dout_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort no_valid", 32'(bad), 32'd0);
    send_frame(3'b110, 1'b1, 1'b1, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      p = odd_par(ODD_PAR_MAX_W'(d)) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s, 3, $sformatf("rnd%0d", i));
    end

    // Back-to-back parity-error frames: start bit lands in the dout_valid cycle.
    for (int i = 0; i < 260; i++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      p = ~odd_par(ODD_PAR_MAX_W'(d));
      send_frame(d, p, 1'b1, 0, $sformatf("sat%0d", i));
    end
    chk("sat final", 32'(err_cnt), 32'(CNT_MAX));

    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_serial_chk.md
# parity_serial_chk

Serial frame receiver and odd-parity checker that sits directly downstream of the 3-bit parity generator. It collects a start bit, W data bits, the generated parity bit and a stop bit from a bit-serial link, one bit per `sin_valid` strobe. It then presents the deserialised word with parity and framing status. Parity convention matches the generator: `p = ~^data`, so a good frame has an odd count of ones across data plus parity.

## Interface
- `W`, default 3: data bits per frame; legal range 1..16.
- `CNT_W`, default 8: width of the saturating error counter.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sin`  in  1: serial data, line idles high.
- `sin_valid`  in  1: one-cycle strobe; `sin` is sampled only when high.
- `dout`  out  W: received data word, LSB first on the wire.
- `dout_valid`  out  1: one-cycle pulse, frame complete.
- `par_err`  out  1: parity failure for the current `dout`; valid with `dout_valid`, held until the next frame completes.
- `frm_err`  out  1: stop bit was 0; same timing as `par_err`.
- `err_cnt`  out  CNT_W: count of frames with `par_err` or `frm_err` set; saturates at all-ones.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states are IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with `sin_valid=1`; with `sin_valid=0` the state, bit counter and shift register hold.
- IDLE:
  - `sin=0` is the start bit; go to DATA and clear the bit counter.
  - `sin=1` is ignored.
- DATA:
  - Shift `sin` into `shreg[W-1]` and shift right, so the first bit received lands in `dout[0]`.
  - Increment the bit counter; after the W-th bit go to PARITY.
- PARITY: latch `sin` as `pbit`; go to STOP.
- STOP: on the stop bit strobe, in the same clock edge:
  - `dout <= shreg`
  - `par_err <= ~(^shreg ^ pbit)`
  - `frm_err <= ~sin`
  - `dout_valid <= 1`
  - `err_cnt` increments if either error is set, unless already all-ones.
  - Go to IDLE.
- A framing error still delivers `dout` and pulses `dout_valid`.
- There is no resynchronisation: after STOP the block always returns to IDLE and waits for the next 0.

## Timing
- Reset values:
  - `dout=0`, `dout_valid=0`, `par_err=0`, `frm_err=0`, `err_cnt=0`, `busy=0`.
  - State is IDLE, bit counter 0, `shreg=0`, `pbit=0`.
- A frame takes exactly W+3 accepted strobes.
- `dout_valid` is asserted in the cycle after the clock edge that samples the stop bit, and lasts exactly one cycle.
- `dout`, `par_err` and `frm_err` change only on that edge or on reset.
- Back-to-back frames: a start bit may arrive on the very next strobe after STOP, including the cycle in which `dout_valid` is high. It is accepted normally.
- Reset asserted mid-frame discards the partial frame immediately, with no `dout_valid`. Reset does not wait for a clock.
- `busy` is registered from the state: high from the cycle after the start bit is accepted until the cycle after the stop bit is accepted.

## Structure
- Shared package `parity_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP; 2-bit encoding);
  - the function `odd_par(data)` returning `~^data`, which is reused by the generator side and by benches.
- Single module with no sub-modules. The bit counter is `$clog2(W+1)` bits wide.

## Test plan
- W=3, data 3'b101 sent as strobes 0,1,0,1,1,1 (start, d0..d2, parity=1, stop) -> `dout=3'b101`, `dout_valid` one cycle, `par_err=0`, `frm_err=0`, `err_cnt=0`.
- Same frame with parity bit 0 -> `dout=3'b101`, `par_err=1`, `err_cnt=1`.
- Data 3'b000, parity 1, stop bit 0 -> `par_err=0`, `frm_err=1`, `dout_valid` still pulses, `err_cnt` +1.
- Random `sin_valid` gaps of 0-5 cycles within a frame, and 10 idle strobes with `sin=1` before the start -> identical result to the gap-free case; `busy` stays 0 during the idle strobes.
- Assert `rst_n=0` after the second data bit, then release and send a full 3'b110 frame (parity 1) -> no `dout_valid` for the aborted frame; next result `dout=3'b110`, `par_err=0`.
- 260 consecutive parity-error frames with CNT_W=8 -> `err_cnt` reaches 255 and holds; back-to-back frames with the start bit on the `dout_valid` cycle are all received.
